// File: rtl/debug_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// debug_tx_arbiter_pkg
//   Shared definitions for the debug UART arbiter and its round-robin picker:
//   the FSM state encoding, the UART byte width, and a width helper that never
//   returns less than one bit.
// -----------------------------------------------------------------------------
package debug_tx_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_TX = 2'd2
  } state_e;

  // Index / counter width for 'value' distinct values; at least one bit so
  // single-client or timeout-disabled builds still have a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debug_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// debug_tx_arbiter_rr_pick
//   Combinational round-robin picker, reusable by any arbiter.
//   Ports:
//     req_i  [N]      request vector
//     ptr_i  [IDX_W]  index of the most recent winner
//     any_o           at least one request is set
//     idx_o  [IDX_W]  first requesting index after ptr_i, wrapping modulo N
// -----------------------------------------------------------------------------
module debug_tx_arbiter_rr_pick
  import debug_tx_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    // Scan from the farthest candidate to the nearest, so the nearest valid
    // index after the pointer is the last (winning) assignment.
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/debug_tx_arbiter.sv
// -----------------------------------------------------------------------------
// debug_tx_arbiter
//   Shares one uart_tx byte transmitter between NUM_CLIENTS debug text sources.
//   Grants are round-robin and last per message: the owner keeps the UART until
//   it sends a byte tagged last. A watchdog releases an owner that stalls in
//   SEND for TIMEOUT cycles (TIMEOUT = 0 disables it).
//   Ports:
//     clk_i            system clock
//     reset_ni         synchronous, active-low reset
//     cl_valid_i [N]   client i has a byte on cl_data_i[8i+:8]
//     cl_data_i  [8N]  packed client bytes
//     cl_last_i  [N]   current byte ends the message
//     cl_ready_o [N]   one-hot take strobe (byte taken on valid & ready)
//     tx_req_o         byte pending for uart_tx
//     tx_data_o  [8]   byte for uart_tx, stable while tx_req_o = 1
//     tx_ready_i       uart_tx idle and accepting
//     grant_valid_o    a client owns the UART
//     grant_id_o       owning client index
//     timeout_pulse_o  one-cycle strobe on a forced release
// -----------------------------------------------------------------------------
module debug_tx_arbiter
  import debug_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS = 4,
  parameter  int unsigned TIMEOUT     = 4096,
  localparam int unsigned ID_W        = clog2_min1(NUM_CLIENTS),
  localparam int unsigned TMR_W       = clog2_min1(TIMEOUT + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NUM_CLIENTS-1:0]        cl_valid_i,
  input  logic [BYTE_W*NUM_CLIENTS-1:0] cl_data_i,
  input  logic [NUM_CLIENTS-1:0]        cl_last_i,
  output logic [NUM_CLIENTS-1:0]        cl_ready_o,
  output logic                          tx_req_o,
  output logic [BYTE_W-1:0]             tx_data_o,
  input  logic                          tx_ready_i,
  output logic                          grant_valid_o,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          timeout_pulse_o
);

  state_e            state_q;
  logic              grant_valid_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [ID_W-1:0]   ptr_q;
  logic              tx_req_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              last_q;
  logic [TMR_W-1:0]  timer_q;
  logic              timeout_pulse_q;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [BYTE_W-1:0] own_data;
  logic              timer_hit;

  debug_tx_arbiter_rr_pick #(.N(NUM_CLIENTS)) u_rr_pick (
    .req_i (cl_valid_i),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign own_valid = cl_valid_i[grant_id_q];
  assign own_last  = cl_last_i[grant_id_q];
  assign own_data  = cl_data_i[grant_id_q*BYTE_W +: BYTE_W];
  assign timer_hit = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));

  // The take strobe depends on state only, so a client can hold its byte on
  // the bus without a combinational loop through valid.
  always_comb begin
    cl_ready_o = '0;
    if (state_q == ST_SEND) cl_ready_o[grant_id_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q         <= ST_IDLE;
      grant_valid_q   <= 1'b0;
      grant_id_q      <= '0;
      ptr_q           <= ID_W'(NUM_CLIENTS - 1);  // client 0 wins first
      tx_req_q        <= 1'b0;
      tx_data_q       <= '0;
      last_q          <= 1'b0;
      timer_q         <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id_q    <= pick_idx;
            grant_valid_q <= 1'b1;
            state_q       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (own_valid) begin
            tx_data_q <= own_data;
            tx_req_q  <= 1'b1;
            last_q    <= own_last;
            timer_q   <= '0;
            state_q   <= ST_WAIT_TX;
          end else if (timer_hit) begin
            grant_valid_q   <= 1'b0;
            ptr_q           <= grant_id_q;
            timer_q         <= '0;
            timeout_pulse_q <= 1'b1;
            state_q         <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_WAIT_TX: begin
          // The watchdog is frozen here: a slow UART is not a stalled client.
          if (tx_ready_i) begin
            tx_req_q <= 1'b0;
            if (last_q) begin
              grant_valid_q <= 1'b0;
              ptr_q         <= grant_id_q;
              timer_q       <= '0;
              state_q       <= ST_IDLE;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_req_o        = tx_req_q;
  assign tx_data_o       = tx_data_q;
  assign grant_valid_o   = grant_valid_q;
  assign grant_id_o      = grant_id_q;
  assign timeout_pulse_o = timeout_pulse_q;

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_debug_tx_arbiter
//   Two arbiters (4 clients and 1 client, watchdog of 8 cycles) driven by
//   queue-backed clients. A message-level model predicts every output on every
//   cycle; directed scenarios add hand-computed byte orders and timings.
// -----------------------------------------------------------------------------
module tb_debug_tx_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  v4, l4, rdy4;
  logic [31:0] d4;
  logic        txr4, txrdy4, gv4, tp4;
  logic [7:0]  txd4;
  logic [1:0]  gid4;
  logic [0:0]  v1, l1, rdy1, gid1;
  logic [7:0]  d1, txd1;
  logic        txr1, txrdy1, gv1, tp1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit cmp_on = 1'b0;

  logic [8:0] cq[5][$];   // per-client {last, byte}; entry 4 feeds the 1-client DUT
  int sent4[$];           // accepted bytes: owner*256 + data
  int sent1[$];

  debug_tx_arbiter #(.NUM_CLIENTS(4), .TIMEOUT(TO)) dut4 (
    .clk_i(clk), .reset_ni(rst_n), .cl_valid_i(v4), .cl_data_i(d4),
    .cl_last_i(l4), .cl_ready_o(rdy4), .tx_req_o(txr4), .tx_data_o(txd4),
    .tx_ready_i(txrdy4), .grant_valid_o(gv4), .grant_id_o(gid4),
    .timeout_pulse_o(tp4)
  );

  debug_tx_arbiter #(.NUM_CLIENTS(1), .TIMEOUT(TO)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .cl_valid_i(v1), .cl_data_i(d1),
    .cl_last_i(l1), .cl_ready_o(rdy1), .tx_req_o(txr1), .tx_data_o(txd1),
    .tx_ready_i(txrdy1), .grant_valid_o(gv1), .grant_id_o(gid1),
    .timeout_pulse_o(tp1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- message-level model ----------------
  // owner < 0 means the UART is free; a byte in flight means waiting on UART.
  int         m_n[2]     = '{4, 1};
  int         m_owner[2] = '{-1, -1};
  int         m_gid[2]   = '{0, 0};
  int         m_ptr[2]   = '{3, 0};
  int         m_idle[2]  = '{0, 0};
  bit         m_req[2]   = '{1'b0, 1'b0};
  bit         m_last[2]  = '{1'b0, 1'b0};
  bit         m_pulse[2] = '{1'b0, 1'b0};
  logic [7:0] m_data[2]  = '{8'h00, 8'h00};

  task automatic model_step(input int m, input logic [3:0] v, input logic [31:0] d,
                            input logic [3:0] l, input logic rdy);
    int n = m_n[m];
    if (!rst_n) begin
      m_owner[m] = -1; m_gid[m] = 0; m_ptr[m] = n - 1; m_idle[m] = 0;
      m_req[m] = 1'b0; m_last[m] = 1'b0; m_pulse[m] = 1'b0; m_data[m] = 8'h00;
    end else begin
      m_pulse[m] = 1'b0;
      if (m_owner[m] < 0) begin
        for (int k = 1; k <= n; k++) begin
          if (m_owner[m] < 0 && v[(m_ptr[m] + k) % n]) m_owner[m] = (m_ptr[m] + k) % n;
        end
        if (m_owner[m] >= 0) m_gid[m] = m_owner[m];
      end else if (m_req[m]) begin
        if (rdy) begin
          m_req[m] = 1'b0;
          if (m_last[m]) begin m_ptr[m] = m_owner[m]; m_owner[m] = -1; m_idle[m] = 0; end
        end
      end else if (v[m_owner[m]]) begin
        m_req[m] = 1'b1; m_data[m] = d[m_owner[m]*8 +: 8];
        m_last[m] = l[m_owner[m]]; m_idle[m] = 0;
      end else if (m_idle[m] == TO - 1) begin
        m_pulse[m] = 1'b1; m_ptr[m] = m_owner[m]; m_owner[m] = -1; m_idle[m] = 0;
      end else begin
        m_idle[m]++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, v4, d4, l4, txrdy4);
    model_step(1, {3'b000, v1}, {24'h0, d1}, {3'b000, l1}, txrdy1);
    cycle++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("cl_ready4", {28'h0, rdy4},
            (m_owner[0] >= 0 && !m_req[0]) ? (32'd1 << m_owner[0]) : 32'd0);
      check("tx_req4", {31'h0, txr4}, {31'h0, m_req[0]});
      if (m_req[0]) check("tx_data4", {24'h0, txd4}, {24'h0, m_data[0]});
      check("grant_valid4", {31'h0, gv4}, (m_owner[0] >= 0) ? 32'd1 : 32'd0);
      if (m_owner[0] >= 0) check("grant_id4", {30'h0, gid4}, m_gid[0]);
      check("timeout4", {31'h0, tp4}, {31'h0, m_pulse[0]});
      check("cl_ready1", {31'h0, rdy1}, (m_owner[1] >= 0 && !m_req[1]) ? 32'd1 : 32'd0);
      check("tx_req1", {31'h0, txr1}, {31'h0, m_req[1]});
      if (m_req[1]) check("tx_data1", {24'h0, txd1}, {24'h0, m_data[1]});
      check("grant_valid1", {31'h0, gv1}, (m_owner[1] >= 0) ? 32'd1 : 32'd0);
      check("timeout1", {31'h0, tp1}, {31'h0, m_pulse[1]});
    end
    // tx_ready only changes just after posedge, so this predicts the next edge.
    if (txr4 && txrdy4) sent4.push_back(int'(gid4) * 256 + int'(txd4));
    if (txr1 && txrdy1) sent1.push_back(int'(txd1));
  end

  // ---------------- clients ----------------
  initial begin
    logic [4:0] take;
    v4 = '0; d4 = '0; l4 = '0; v1 = '0; d1 = '0; l1 = '0;
    forever begin
      @(negedge clk);
      take = {v1 & rdy1, v4 & rdy4};
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++)
        if (take[i] && cq[i].size() > 0) void'(cq[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        v4[i]        = cq[i].size() > 0;
        d4[i*8 +: 8] = (cq[i].size() > 0) ? cq[i][0][7:0] : 8'h00;
        l4[i]        = (cq[i].size() > 0) ? cq[i][0][8] : 1'b0;
      end
      v1[0] = cq[4].size() > 0;
      d1    = (cq[4].size() > 0) ? cq[4][0][7:0] : 8'h00;
      l1[0] = (cq[4].size() > 0) ? cq[4][0][8] : 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_msg(input int c, input string s);
    for (int i = 0; i < s.len(); i++)
      cq[c].push_back({(i == s.len() - 1), s[i]});
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = !gv4 && !gv1 && !txr4 && !txr1 && cq[0].size() == 0 && cq[1].size() == 0
           && cq[2].size() == 0 && cq[3].size() == 0 && cq[4].size() == 0;
    end
    check(name, {31'h0, ok}, 32'd1);
  endtask

  task automatic wait_txr4(input bit level, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = (txr4 == level);
    end
    check(name, {31'h0, ok}, 32'd1);
  endtask

  // owners: one digit per byte; chars: the bytes, in UART order.
  task automatic check_sent(input string name, input string owners, input string chars);
    check({name, "_count"}, sent4.size(), owners.len());
    for (int i = 0; i < owners.len(); i++)
      check(name, (i < sent4.size()) ? sent4[i] : -1,
            (int'(owners[i]) - 48) * 256 + int'(chars[i]));
    sent4.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    int ca, cp, gaps;
    bit ok;
    logic [7:0] held;
    rst_n = 1'b0; txrdy4 = 1'b1; txrdy1 = 1'b1;
    cyc(2);
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_gv", {31'h0, gv4}, 32'd0);
    check("rst_txreq", {31'h0, txr4}, 32'd0);
    check("rst_ready", {28'h0, rdy4}, 32'd0);
    check("rst_gid", {30'h0, gid4}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // 1: client 2 sends "OK"; grant one cycle after valid is seen.
    push_msg(2, "OK");
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = v4[2];
    end
    check("t1_valid_seen", {31'h0, ok}, 32'd1);
    check("t1_no_grant_yet", {31'h0, gv4}, 32'd0);
    @(negedge clk);
    check("t1_grant", {31'h0, gv4}, 32'd1);
    check("t1_gid", {30'h0, gid4}, 32'd2);
    wait_done("t1_done", 50);
    check_sent("t1", "22", "OK");

    // 2: no interleave, then round-robin order after client 0 was last served.
    cyc(1);
    push_msg(0, "abc");
    push_msg(1, "xyz");
    wait_done("t2a_done", 100);
    cyc(1);
    push_msg(0, "d");
    wait_done("t2b_done", 50);
    cyc(1);
    push_msg(0, "e");
    push_msg(1, "f");
    wait_done("t2c_done", 50);
    check_sent("t2", "000111010", "abcxyzdfe");

    // 3: UART busy for 20 cycles with a byte pending.
    cyc(1);
    txrdy4 = 1'b0;
    push_msg(3, "Q!");
    wait_txr4(1'b1, "t3_req");
    held = txd4;
    check("t3_first_byte", {24'h0, held}, 32'h51);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t3_data_stable", {24'h0, txd4}, {24'h0, held});
      check("t3_ready_low", {28'h0, rdy4}, 32'd0);
      check("t3_req_held", {31'h0, txr4}, 32'd1);
    end
    cyc(1);
    txrdy4 = 1'b1;
    wait_done("t3_done", 50);
    check_sent("t3", "33", "Q!");

    // 4: client 1 stalls after one non-last byte; watchdog fires after 8 SEND cycles.
    cyc(1);
    cq[1].push_back({1'b0, 8'h41});
    wait_txr4(1'b1, "t4_req");
    wait_txr4(1'b0, "t4_sent");
    ca = cycle;
    push_msg(3, "Z");
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = tp4;
    end
    cp = cycle;
    check("t4_pulse_seen", {31'h0, ok}, 32'd1);
    check("t4_pulse_cycles", cp - ca, 32'd8);
    @(negedge clk);
    check("t4_next_grant", {31'h0, gv4}, 32'd1);
    check("t4_next_gid", {30'h0, gid4}, 32'd3);
    wait_done("t4_done", 50);
    check_sent("t4", "13", "AZ");

    // 5: reset mid-message with a byte waiting on the UART.
    cyc(1);
    txrdy4 = 1'b0;
    push_msg(1, "RST");
    wait_txr4(1'b1, "t5_req");
    cyc(1);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) cq[i].delete();
    cyc(1);
    @(negedge clk);
    check("t5_rst_txreq", {31'h0, txr4}, 32'd0);
    check("t5_rst_gv", {31'h0, gv4}, 32'd0);
    check("t5_rst_txdata", {24'h0, txd4}, 32'd0);
    check("t5_rst_ready", {28'h0, rdy4}, 32'd0);
    rst_n = 1'b1;
    txrdy4 = 1'b1;
    cyc(1);
    sent4.delete();
    push_msg(1, "b");
    push_msg(0, "a");
    wait_done("t5_done", 50);
    check_sent("t5", "01", "ab");

    // 6: single client, back-to-back one-byte messages.
    cyc(1);
    push_msg(4, "1");
    push_msg(4, "2");
    push_msg(4, "3");
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = gv1;
    end
    check("t6_grant", {31'h0, ok}, 32'd1);
    gaps = 0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (!gv1 && sent1.size() < 3) gaps++;
      ok = (sent1.size() == 3) && !gv1;
    end
    check("t6_finished", {31'h0, ok}, 32'd1);
    check("t6_idle_gaps", gaps, 32'd2);
    check("t6_count", sent1.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check("t6_byte", (i < sent1.size()) ? sent1[i] : -1, 32'h31 + i);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
